imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction-fetch sequencer between the PC/branch logic and the instruction memory. Owns the program counter, drives the memory's fetch strobe and address, waits for the memory's update flag, and presents each instruction to decode on a valid/ready handshake. Also handles redirects, the 0xFFFFFFFF halt sentinel, and address/timeout faults.

## Interface
- RESET_PC, 32'h0100_0000: PC loaded on reset.
- IMEM_BASE_HI, 20'h01000: required value of addr[31:12].
- TIMEOUT, 8: max WAIT cycles without instrf_update before a fault (1..255).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump redirect strobe.
- redirect_pc  in  32  redirect target.
- instrfetch  out  1  fetch strobe to IMEM.
- addr_imem  out  32  fetch address to IMEM.
- instr  in  32  IMEM instruction word, valid while instrf_update=1.
- instrf_update  in  1  IMEM response flag.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  32  captured instruction.
- if_pc  out  32  PC of if_instr.
- halted  out  1  sticky; sentinel fetched.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 misaligned, 10 out of range, 11 timeout.
- fault_pc  out  32  PC that faulted.

## Operation
- States: RESET_S, REQ, WAIT, HOLD, HALT, FAULT.
- RESET_S: pc=RESET_PC; exits to REQ on the first clk edge after rst_n rises.
- REQ: if pc[1:0]!=0, go to FAULT with cause 01. If pc[31:12]!=IMEM_BASE_HI, go to FAULT with cause 10. No strobe is issued in either case. Otherwise drive instrfetch=1 and addr_imem=pc, then go to WAIT with timer=0.
- WAIT: instrfetch=1 and addr_imem=pc are held.
  - instrf_update=1 with instr==32'hFFFF_FFFF: go to HALT. Sentinel never presented.
  - instrf_update=1 otherwise: capture if_instr=instr and if_pc=pc, then go to HOLD.
  - Otherwise timer++. When the timer reaches TIMEOUT, go to FAULT with cause 11.
- HOLD: if_valid=1 and instrfetch=0. On if_valid&&if_ready: pc=pc+4 (32-bit wrap), go to REQ.
- PC leaving the 4 KiB window (e.g. 0x0100_0FFC+4) is not special-cased. It faults with cause 10 at the next REQ.
- Redirect (REQ/WAIT/HOLD): pc=redirect_pc and next state is REQ. Any in-flight or same-cycle response is discarded. if_valid drops next cycle with no handshake. Redirect beats a simultaneous if_ready: no pc+4 occurs.
- HALT and FAULT: terminal; leave only via rst_n. Redirects are ignored. instrfetch=0, if_valid=0. fault_cause and fault_pc hold.

## Timing
- Reset values: instrfetch=0, addr_imem=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0, fault_cause=00, fault_pc=0.
- All outputs are registered; no input-to-output combinational path.
- Nominal IMEM (update one edge after strobe): REQ cycle n, WAIT cycle n+1, if_valid at n+2. With if_ready tied high, one instruction every 3 cycles.
- if_instr and if_pc are stable while if_valid=1 and not accepted.
- rst_n asserted mid-fetch clears the state immediately. The outstanding fetch is abandoned and instrfetch drops asynchronously.

## Structure
- Package imem_fetch_pkg holds:
  - state enum;
  - fault_cause encodings;
  - HALT_SENTINEL=32'hFFFF_FFFF;
  - default IMEM_BASE_HI.
- One sub-module, imem_addr_chk: combinational, takes pc and IMEM_BASE_HI, outputs misaligned and out_of_range. Reusable by the data-memory controller.
- The FSM, timer and PC register stay in imem_fetch_ctrl.

## Test plan
- Reset with IMEM responding next cycle and if_ready=1; word 0=0x0200_0103, word 1=0x0000_0013. Expect:
  - instrfetch addr 0x0100_0000 in the first cycle after reset;
  - if_valid two cycles later with if_instr=0x0200_0103, if_pc=0x0100_0000;
  - next if_pc=0x0100_0004.
- if_ready held low 5 cycles. Expect if_valid, if_instr and if_pc stable, and no new strobe until acceptance.
- redirect_pc=0x0100_0040 during WAIT, with the response in the same cycle. Expect the response dropped, then the next strobe at 0x0100_0040 and if_pc=0x0100_0040.
- Fetch of 32'hFFFF_FFFF. Expect halted=1, if_valid never asserted, and no further strobes despite redirect_valid.
- Redirects with no IMEM responses:
  - redirect to 0x0100_0002: fault=1, cause 01, fault_pc=0x0100_0002, no strobe;
  - redirect to 0x0200_0000: cause 10;
  - IMEM silent for 8 cycles: cause 11.
- Assert rst_n low in the middle of WAIT. Expect all outputs at reset values immediately, and a restart at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_pkg
// Shared types and constants for the instruction-fetch sequencer and the
// address checker it uses.
//   fetch_state_e        : fetch FSM states
//   fault_cause_e        : encodings reported on fault_cause
//   HALT_SENTINEL        : instruction word that halts fetching
//   DEFAULT_IMEM_BASE_HI : required addr[31:12] of the instruction window
// -----------------------------------------------------------------------------
package imem_fetch_pkg;

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    REQ_S   = 3'd1,
    WAIT_S  = 3'd2,
    HOLD_S  = 3'd3,
    HALT_S  = 3'd4,
    FAULT_S = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

  localparam logic [31:0] HALT_SENTINEL        = 32'hFFFF_FFFF;
  localparam logic [19:0] DEFAULT_IMEM_BASE_HI = 20'h01000;
  localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0100_0000;
  localparam int unsigned DEFAULT_TIMEOUT      = 8;

endpackage

// File: rtl/imem_addr_chk.sv
// -----------------------------------------------------------------------------
// imem_addr_chk
// Purely combinational legality check of a word fetch address against a
// 4 KiB memory window. Written generically so a data-memory controller can
// reuse it.
// Ports:
//   i_addr          in  32  address to check
//   i_base_hi       in  20  required value of addr[31:12]
//   o_misaligned    out 1   addr[1:0] is not zero
//   o_out_of_range  out 1   addr[31:12] differs from i_base_hi
// -----------------------------------------------------------------------------
module imem_addr_chk
  import imem_fetch_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [19:0] i_base_hi,
  output logic        o_misaligned,
  output logic        o_out_of_range
);

  assign o_misaligned   = (i_addr[1:0] != 2'b00);
  assign o_out_of_range = (i_addr[31:12] != i_base_hi);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, issues fetch strobes to the
// instruction memory, waits for its response and presents each instruction to
// decode on a valid/ready handshake. Handles redirects, the halt sentinel and
// misaligned / out-of-window / timeout faults. Every output is a register.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   i_redirect_valid   branch/jump redirect strobe
//   i_redirect_pc      redirect target
//   o_instrfetch       fetch strobe to IMEM
//   o_addr_imem        fetch address to IMEM (always the current PC)
//   i_instr            IMEM instruction word, valid with i_instrf_update
//   i_instrf_update    IMEM response flag
//   o_if_valid         instruction available to decode
//   i_if_ready         decode accepts
//   o_if_instr         captured instruction
//   o_if_pc            PC of o_if_instr
//   o_halted           sticky, sentinel fetched
//   o_fault            sticky fault flag
//   o_fault_cause      00 none, 01 misaligned, 10 out of range, 11 timeout
//   o_fault_pc         PC that faulted
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [19:0] IMEM_BASE_HI = DEFAULT_IMEM_BASE_HI,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instrfetch,
  output logic [31:0] o_addr_imem,
  input  logic [31:0] i_instr,
  input  logic        i_instrf_update,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_halted,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic [31:0] o_fault_pc
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  logic [7:0]   r_timer;
  logic [7:0]   w_next_timer;

  // Address legality of the PC currently held, registered alongside it.
  logic         r_misaligned;
  logic         r_out_of_range;
  logic         w_misaligned;
  logic         w_out_of_range;

  logic         w_capture;
  logic         w_halt_set;
  logic         w_fault_set;
  fault_cause_e w_cause;
  logic         w_next_fetch;

  logic         r_instrfetch;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic         r_halted;
  logic         r_fault;
  fault_cause_e r_fault_cause;
  logic [31:0]  r_fault_pc;

  // The checker looks at the PC being loaded, so its verdict is ready as a
  // register in the REQ cycle and the strobe can itself be registered.
  imem_addr_chk u_addr_chk (
    .i_addr         (w_next_pc),
    .i_base_hi      (IMEM_BASE_HI),
    .o_misaligned   (w_misaligned),
    .o_out_of_range (w_out_of_range)
  );

  // Next-state, next-PC, timer and side-effect decode of the fetch FSM.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_timer = r_timer;
    w_capture    = 1'b0;
    w_halt_set   = 1'b0;
    w_fault_set  = 1'b0;
    w_cause      = CAUSE_NONE;
    case (r_state)
      RESET_S: begin
        w_next_state = REQ_S;
      end
      REQ_S: begin
        if (i_redirect_valid) begin
          w_next_pc    = i_redirect_pc;
          w_next_state = REQ_S;
        end else if (r_misaligned) begin
          w_next_state = FAULT_S;
          w_fault_set  = 1'b1;
          w_cause      = CAUSE_MISALIGN;
        end else if (r_out_of_range) begin
          w_next_state = FAULT_S;
          w_fault_set  = 1'b1;
          w_cause      = CAUSE_RANGE;
        end else begin
          w_next_state = WAIT_S;
          w_next_timer = 8'd0;
        end
      end
      WAIT_S: begin
        // A redirect discards any response arriving in the same cycle.
        if (i_redirect_valid) begin
          w_next_pc    = i_redirect_pc;
          w_next_state = REQ_S;
        end else if (i_instrf_update) begin
          if (i_instr == HALT_SENTINEL) begin
            w_next_state = HALT_S;
            w_halt_set   = 1'b1;
          end else begin
            w_next_state = HOLD_S;
            w_capture    = 1'b1;
          end
        end else if ((r_timer + 8'd1) == TIMEOUT_CNT) begin
          w_next_state = FAULT_S;
          w_fault_set  = 1'b1;
          w_cause      = CAUSE_TIMEOUT;
        end else begin
          w_next_timer = r_timer + 8'd1;
        end
      end
      HOLD_S: begin
        // Redirect wins over a simultaneous accept: no pc+4 in that case.
        if (i_redirect_valid) begin
          w_next_pc    = i_redirect_pc;
          w_next_state = REQ_S;
        end else if (i_if_ready) begin
          w_next_pc    = r_pc + 32'd4;
          w_next_state = REQ_S;
        end else begin
          w_next_state = HOLD_S;
        end
      end
      HALT_S: begin
        w_next_state = HALT_S;
      end
      FAULT_S: begin
        w_next_state = FAULT_S;
      end
      default: begin
        w_next_state = RESET_S;
        w_next_pc    = RESET_PC;
      end
    endcase
  end

  // The strobe is high in WAIT and in a REQ whose PC is legal.
  assign w_next_fetch = (w_next_state == WAIT_S) ||
                        ((w_next_state == REQ_S) && !w_misaligned && !w_out_of_range);

  // FSM state, PC, wait timer and registered address verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RESET_S;
      r_pc           <= RESET_PC;
      r_timer        <= 8'd0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_pc           <= w_next_pc;
      r_timer        <= w_next_timer;
      r_misaligned   <= w_misaligned;
      r_out_of_range <= w_out_of_range;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrfetch  <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'd0;
      r_if_pc       <= 32'd0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_cause <= CAUSE_NONE;
      r_fault_pc    <= 32'd0;
    end else begin
      r_instrfetch <= w_next_fetch;
      r_if_valid   <= (w_next_state == HOLD_S);
      if (w_capture) begin
        r_if_instr <= i_instr;
        r_if_pc    <= r_pc;
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
      if (w_fault_set) begin
        r_fault       <= 1'b1;
        r_fault_cause <= w_cause;
        r_fault_pc    <= r_pc;
      end
    end
  end

  assign o_instrfetch  = r_instrfetch;
  assign o_addr_imem   = r_pc;
  assign o_if_valid    = r_if_valid;
  assign o_if_instr    = r_if_instr;
  assign o_if_pc       = r_if_pc;
  assign o_halted      = r_halted;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_fault_cause;
  assign o_fault_pc    = r_fault_pc;

endmodule
